// File: rtl/matrix_multiply_3x3.sv
// rtl/matrix_multiply_3x3.sv - streaming fixed-point C = A x B with a single MAC
module matrix_multiply_3x3 #(
  parameter int W    = 16,
  parameter int FRAC = 8,
  parameter int N    = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         out_last_o,
  output logic         busy_o,
  output logic         ovf_o
);

  localparam int NN = N * N;
  localparam int EW = $clog2(NN);
  localparam int CW = $clog2(2 * NN);
  localparam int KW = $clog2(N);
  localparam int AW = 2 * W + $clog2(N);
  localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (W - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-(1 << (W - 1)));
  localparam logic [KW-1:0] KMAX = KW'(N - 1);

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

  state_t state_q, state_d;
  logic live_q, live_d;
  logic [CW-1:0] ld_cnt_q, ld_cnt_d;
  logic [KW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [EW-1:0] idx_q, idx_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic ovf_q, ovf_d;

  logic signed [W-1:0] a_q [NN];
  logic signed [W-1:0] b_q [NN];
  logic signed [W-1:0] c_q [NN];

  logic a_we, b_we, c_we;
  logic [CW-1:0] b_wr;
  logic [EW-1:0] a_rd, b_rd, c_wr;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0] acc_sum, shifted;
  logic sat_hi, sat_lo;
  logic [W-1:0] c_val;

  // Datapath: one product per cycle, element result taken from the running sum.
  always_comb begin
    a_rd    = EW'(i_q * N + k_q);
    b_rd    = EW'(k_q * N + j_q);
    c_wr    = EW'(i_q * N + j_q);
    b_wr    = ld_cnt_q - CW'(NN);
    prod    = a_q[a_rd] * b_q[b_rd];
    acc_sum = acc_q + AW'(prod);
    shifted = acc_sum >>> FRAC;
    sat_hi  = shifted > SAT_MAX;
    sat_lo  = shifted < SAT_MIN;
    c_val   = sat_hi ? SAT_MAX[W-1:0] : (sat_lo ? SAT_MIN[W-1:0] : shifted[W-1:0]);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    in_ready_o  = live_q && (state_q == LOAD);
    out_valid_o = (state_q == DRAIN);
    out_last_o  = out_valid_o && (idx_q == EW'(NN - 1));
    out_data_o  = out_valid_o ? c_q[idx_q] : '0;
    busy_o      = (state_q == COMPUTE) || (state_q == DRAIN);
    ovf_o       = ovf_q;

    state_d  = state_q;
    live_d   = 1'b1;
    ld_cnt_d = ld_cnt_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    a_we     = 1'b0;
    b_we     = 1'b0;
    c_we     = 1'b0;

    case (state_q)
      LOAD: begin
        if (in_valid_i && in_ready_o) begin
          if (ld_cnt_q == '0) ovf_d = 1'b0;
          if (ld_cnt_q < CW'(NN)) a_we = 1'b1;
          else                    b_we = 1'b1;
          if (ld_cnt_q == CW'(2 * NN - 1)) begin
            ld_cnt_d = '0;
            state_d  = COMPUTE;
          end else begin
            ld_cnt_d = ld_cnt_q + CW'(1);
          end
        end
      end
      COMPUTE: begin
        if (k_q == KMAX) begin
          k_d   = '0;
          acc_d = '0;
          c_we  = 1'b1;
          if (sat_hi || sat_lo) ovf_d = 1'b1;
          if (j_q == KMAX) begin
            j_d = '0;
            if (i_q == KMAX) begin
              i_d     = '0;
              state_d = DRAIN;
            end else begin
              i_d = i_q + KW'(1);
            end
          end else begin
            j_d = j_q + KW'(1);
          end
        end else begin
          k_d   = k_q + KW'(1);
          acc_d = acc_sum;
        end
      end
      DRAIN: begin
        if (out_ready_i) begin
          if (idx_q == EW'(NN - 1)) begin
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            idx_d = idx_q + EW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      live_q   <= 1'b0;
      ld_cnt_q <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      for (int n = 0; n < NN; n++) begin
        a_q[n] <= '0;
        b_q[n] <= '0;
        c_q[n] <= '0;
      end
    end else begin
      live_q   <= live_d;
      ld_cnt_q <= ld_cnt_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      if (a_we) a_q[ld_cnt_q[EW-1:0]] <= in_data_i;
      if (b_we) b_q[b_wr[EW-1:0]] <= in_data_i;
      if (c_we) c_q[c_wr] <= c_val;
    end
  end

endmodule

// File: tb/tb_matrix_multiply_3x3.sv
// tb/tb_matrix_multiply_3x3.sv - directed bench with a reference matrix-product model
module tb_matrix_multiply_3x3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [15:0] in_data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_data_o;
  logic        out_last_o;
  logic        busy_o;
  logic        ovf_o;

  always #5 clk_i = ~clk_i;

  matrix_multiply_3x3 dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_last_o (out_last_o),
    .busy_o     (busy_o),
    .ovf_o      (ovf_o)
  );

  int          vectors = 0;
  int          miscompares = 0;
  shortint     ma [9];
  shortint     mb [9];
  logic [16:0] exp_q [$];
  logic [15:0] obs_q [$];
  bit          exp_ovf;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference: real matrix product in wide integers, floor by 2^8, clamp to 16 bits.
  task automatic model_push();
    exp_ovf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        longint s = 0;
        for (int k = 0; k < 3; k++) s += longint'(ma[i*3+k]) * longint'(mb[k*3+j]);
        s = s >>> 8;
        if (s > 32767) begin
          s = 32767;
          exp_ovf = 1'b1;
        end else if (s < -32768) begin
          s = -32768;
          exp_ovf = 1'b1;
        end
        exp_q.push_back({(i == 2 && j == 2), 16'(s)});
      end
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {out_last_o, out_data_o}, 17'h1ffff);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("c_element", {15'd0, out_last_o, out_data_o}, {15'd0, e});
        obs_q.push_back(out_data_o);
      end
    end
  end

  task automatic send_word(input logic [15:0] w);
    int g = 0;
    in_valid_i = 1'b1;
    in_data_i  = w;
    while (!in_ready_o && g < 50) begin
      @(posedge clk_i); #1;
      g++;
    end
    if (g >= 50) check("in_ready_timeout", in_ready_o, 1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic load_op(input bit push);
    if (push) model_push();
    for (int n = 0; n < 18; n++) begin
      send_word(n < 9 ? 16'(ma[n]) : 16'(mb[n-9]));
      if (n == 0) check("ovf_clear_on_load", ovf_o, 0);
    end
  endtask

  task automatic drain(input int mode);
    int cyc = 0;
    int stall = 0;
    int hs;
    logic [15:0] held = '0;
    while (exp_q.size() != 0 && cyc < 200) begin
      hs = 9 - exp_q.size();
      check("in_ready_low_in_drain", in_ready_o, 0);
      if (mode == 0 || hs < 3) begin
        out_ready_i = 1'b1;
      end else if (stall < 5) begin
        out_ready_i = 1'b0;
        if (stall == 0) held = out_data_o;
        else begin
          check("stall_data_stable", out_data_o, held);
          check("stall_valid_high", out_valid_o, 1);
        end
        stall++;
      end else begin
        out_ready_i = ~out_ready_i;
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    if (cyc >= 200) check("drain_timeout", exp_q.size(), 0);
    out_ready_i = 1'b0;
    check("valid_low_after_drain", out_valid_o, 0);
    check("in_ready_after_drain", in_ready_o, 1);
  endtask

  task automatic run_op(input int mode);
    int lat = 0;
    obs_q.delete();
    out_ready_i = 1'b0;
    load_op(1);
    while (!out_valid_o && lat < 100) begin
      check("in_ready_low_compute", in_ready_o, 0);
      check("busy_compute", busy_o, 1);
      in_valid_i = lat[0];
      in_data_i  = 16'($urandom);
      @(posedge clk_i); #1;
      lat++;
    end
    in_valid_i = 1'b0;
    check("latency", lat, 27);
    drain(mode);
    check("ovf_result", ovf_o, exp_ovf);
    check("obs_count", obs_q.size(), 9);
  endtask

  task automatic set_all(input logic [15:0] av, input logic [15:0] bv);
    for (int n = 0; n < 9; n++) begin
      ma[n] = shortint'(av);
      mb[n] = shortint'(bv);
    end
  endtask

  task automatic set_identity();
    for (int n = 0; n < 9; n++) begin
      ma[n] = (n % 4 == 0) ? 16'sh0100 : 16'sh0000;
      mb[n] = shortint'(16'h0100 * (n + 1));
    end
  endtask

  task automatic check_identity();
    if (obs_q.size() == 9)
      for (int n = 0; n < 9; n++) check("identity_literal", obs_q[n], 16'h0100 * (n + 1));
    check("identity_ovf", ovf_o, 0);
  endtask

  task automatic check_all_obs(input string name, input logic [15:0] want);
    if (obs_q.size() == 9)
      for (int n = 0; n < 9; n++) check(name, obs_q[n], want);
  endtask

  initial begin
    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_in_ready", in_ready_o, 0);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_out_last", out_last_o, 0);
    check("rst_out_data", out_data_o, 0);
    rst_i = 1'b0;
    #1;
    check("in_ready_before_edge", in_ready_o, 0);
    @(posedge clk_i); #1;
    check("in_ready_after_edge", in_ready_o, 1);

    set_identity();
    run_op(0);
    check_identity();

    ma = '{16'sh0100, 16'sh0200, 16'sh0000, -16'sh0100, 16'sh0080, 16'sh0300, 16'sh0040, 16'sh0000, -16'sh0200};
    mb = '{16'sh0100, -16'sh0080, 16'sh0200, 16'sh0300, 16'sh0100, -16'sh0040, 16'sh0040, 16'sh0180, 16'sh0100};
    run_op(0);
    if (obs_q.size() == 9) begin
      check("mixed_c00", obs_q[0], 16'h0700);
      check("mixed_c10", obs_q[3], 16'h0140);
    end

    set_all(16'hFFFF, 16'h0080);
    run_op(0);
    check_all_obs("round_floor", 16'hFFFE);
    check("round_ovf", ovf_o, 0);

    set_all(16'h7F00, 16'h7F00);
    run_op(0);
    check_all_obs("sat_pos", 16'h7FFF);
    check("sat_pos_ovf", ovf_o, 1);
    repeat (2) @(posedge clk_i);
    #1;
    check("ovf_held_idle", ovf_o, 1);
    set_all(16'h8000, 16'h7F00);
    run_op(0);
    check_all_obs("sat_neg", 16'h8000);
    check("sat_neg_ovf", ovf_o, 1);

    ma = '{16'sh0100, 16'sh0200, 16'sh0000, -16'sh0100, 16'sh0080, 16'sh0300, 16'sh0040, 16'sh0000, -16'sh0200};
    mb = '{16'sh0100, -16'sh0080, 16'sh0200, 16'sh0300, 16'sh0100, -16'sh0040, 16'sh0040, 16'sh0180, 16'sh0100};
    run_op(1);
    if (obs_q.size() == 9) check("bp_c00", obs_q[0], 16'h0700);

    set_identity();
    load_op(0);
    repeat (10) @(posedge clk_i);
    #3;
    rst_i = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_out_valid", out_valid_o, 0);
    check("mid_rst_ovf", ovf_o, 0);
    check("mid_rst_out_data", out_data_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("release_in_ready_low", in_ready_o, 0);
    @(posedge clk_i); #1;
    check("release_in_ready_high", in_ready_o, 1);
    set_identity();
    run_op(0);
    check_identity();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
